// File: rtl/txc_sched_rx.sv
// ---------------------------------------------------------------------------
// txc_sched_rx_fifo
//   One per egress port. Holds up to DEPTH dispatch descriptors in arrival
//   order and exposes the head combinationally.
//   clk, arst_n        clock, async active-low reset
//   wr_req             descriptor presented for this port this cycle
//   wr_ptr / wr_len    descriptor payload
//   rd_en              pop the head (only asserted when not_empty)
//   not_empty          at least one descriptor stored (registered state only)
//   head_ptr/head_len  descriptor at the read pointer
//   ovf                sticky: a write arrived while full and not popped
// ---------------------------------------------------------------------------
module txc_sched_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 20,
  parameter int LEN_W = 14
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             wr_req,
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [LEN_W-1:0] wr_len,
  input  logic             rd_en,
  output logic             not_empty,
  output logic [PTR_W-1:0] head_ptr,
  output logic [LEN_W-1:0] head_len,
  output logic             ovf
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  typedef struct packed {
    logic [PTR_W-1:0] ptr;
    logic [LEN_W-1:0] len;
  } desc_t;

  desc_t            mem [DEPTH];
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [CNT_W-1:0] count;
  logic             wr_acc;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] i);
    return (i == LAST) ? '0 : i + 1'b1;
  endfunction

  // A full FIFO still takes the write when its head leaves this same cycle:
  // the freed slot is the one the write pointer already points at.
  assign wr_acc    = wr_req & ((count < FULL) | rd_en);
  assign not_empty = (count != '0);
  assign head_ptr  = mem[rd_idx].ptr;
  assign head_len  = mem[rd_idx].len;

  // Storage needs no reset; count==0 makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_idx] <= '{ptr: wr_ptr, len: wr_len};
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_acc) wr_idx <= nxt(wr_idx);
      if (rd_en)  rd_idx <= nxt(rd_idx);
      case ({wr_acc, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (wr_req && !wr_acc) ovf <= 1'b1;
    end
  end

endmodule

// ---------------------------------------------------------------------------
// txc_sched_rx
//   Transmit-controller end of the scheduler dispatch path. Descriptors from
//   the scheduler land in per-port FIFOs (never back-pressured; overflow is
//   dropped and flagged), are issued through a single output register under
//   round-robin arbitration gated by per-port PFC pause, and every pop hands
//   one credit back to the scheduler.
//   clk, arst_n                 clock, async active-low reset
//   sched_valid/port/ptr/len    incoming descriptor
//   credit_valid/credit_port    one credit returned per popped entry
//   tx_valid/port/ptr/len       offered descriptor, held while !tx_ready
//   tx_ready                    transmit datapath accepts
//   tx_pause                    per-port pause, sampled at arbitration only
//   ovf_err                     sticky per-port overflow flags
// ---------------------------------------------------------------------------
module txc_sched_rx #(
  parameter int NUM_PORTS = 4,
  parameter int DEPTH     = 4,
  parameter int PTR_W     = 20,
  parameter int LEN_W     = 14,
  parameter int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 sched_valid,
  input  logic [PORT_W-1:0]    sched_port,
  input  logic [PTR_W-1:0]     sched_ptr,
  input  logic [LEN_W-1:0]     sched_len,
  output logic                 credit_valid,
  output logic [PORT_W-1:0]    credit_port,
  output logic                 tx_valid,
  output logic [PORT_W-1:0]    tx_port,
  output logic [PTR_W-1:0]     tx_ptr,
  output logic [LEN_W-1:0]     tx_len,
  input  logic                 tx_ready,
  input  logic [NUM_PORTS-1:0] tx_pause,
  output logic [NUM_PORTS-1:0] ovf_err
);

  // The credit leaves two registers after the pop decision, so a descriptor
  // written at cycle N returns its credit at N+3.
  localparam int CRD_STAGES = 2;

  logic [NUM_PORTS-1:0]             wr_req, pop, not_empty, elig;
  logic [NUM_PORTS-1:0][PTR_W-1:0]  head_ptr;
  logic [NUM_PORTS-1:0][LEN_W-1:0]  head_len;
  logic [PORT_W-1:0]                rr_ptr, win, idx;
  logic                             found, load;
  logic [CRD_STAGES:1]              vld_pipe;
  logic [CRD_STAGES:1][PORT_W-1:0]  port_pipe;

  // Eligibility uses registered FIFO state only, so a same-cycle write is
  // never bypassed to the output register.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign wr_req[p] = sched_valid & (sched_port == PORT_W'(p));
    assign elig[p]   = not_empty[p] & ~tx_pause[p];
    assign pop[p]    = load & found & (win == PORT_W'(p));

    txc_sched_rx_fifo #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W),
      .LEN_W (LEN_W)
    ) u_fifo (
      .clk       (clk),
      .arst_n    (arst_n),
      .wr_req    (wr_req[p]),
      .wr_ptr    (sched_ptr),
      .wr_len    (sched_len),
      .rd_en     (pop[p]),
      .not_empty (not_empty[p]),
      .head_ptr  (head_ptr[p]),
      .head_len  (head_len[p]),
      .ovf       (ovf_err[p])
    );
  end

  // Rotating-priority search starting at rr_ptr; NUM_PORTS is a power of
  // two so the index wraps naturally.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = rr_ptr + PORT_W'(i);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Output register refills when empty or when its content is taken.
  assign load = ~tx_valid | tx_ready;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tx_valid <= 1'b0;
      tx_port  <= '0;
      tx_ptr   <= '0;
      tx_len   <= '0;
      rr_ptr   <= '0;
    end else if (load) begin
      tx_valid <= found;
      if (found) begin
        tx_port <= win;
        tx_ptr  <= head_ptr[win];
        tx_len  <= head_len[win];
        rr_ptr  <= win + 1'b1;
      end
    end
  end

  // Credit return pipeline; port is zeroed on idle stages.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      vld_pipe  <= '0;
      port_pipe <= '0;
    end else begin
      vld_pipe[1]  <= |pop;
      port_pipe[1] <= (|pop) ? win : '0;
      for (int s = 2; s <= CRD_STAGES; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        port_pipe[s] <= port_pipe[s-1];
      end
    end
  end

  assign credit_valid = vld_pipe[CRD_STAGES];
  assign credit_port  = port_pipe[CRD_STAGES];

endmodule

// File: tb/tb_txc_sched_rx.sv
// Bench for txc_sched_rx: scenario tasks drive descriptors and push the
// expected issue/credit sequence; a forked monitor pops and compares on
// every transfer and every credit.
module tb_txc_sched_rx;

  localparam int NUM_PORTS = 4;
  localparam int DEPTH     = 4;
  localparam int PTR_W     = 20;
  localparam int LEN_W     = 14;
  localparam int PORT_W    = 2;

  logic                 clk = 1'b0;
  logic                 arst_n = 1'b0;
  logic                 sched_valid;
  logic [PORT_W-1:0]    sched_port;
  logic [PTR_W-1:0]     sched_ptr;
  logic [LEN_W-1:0]     sched_len;
  logic                 credit_valid;
  logic [PORT_W-1:0]    credit_port;
  logic                 tx_valid;
  logic [PORT_W-1:0]    tx_port;
  logic [PTR_W-1:0]     tx_ptr;
  logic [LEN_W-1:0]     tx_len;
  logic                 tx_ready;
  logic [NUM_PORTS-1:0] tx_pause;
  logic [NUM_PORTS-1:0] ovf_err;

  typedef struct packed {
    logic [PORT_W-1:0] port;
    logic [PTR_W-1:0]  ptr;
    logic [LEN_W-1:0]  len;
  } desc_t;

  desc_t             exp_tx[$];
  logic [PORT_W-1:0] exp_crd[$];
  int n_checks = 0;
  int n_fails = 0;
  int credit_seen = 0;

  always #5 clk = ~clk;

  txc_sched_rx #(
    .NUM_PORTS (NUM_PORTS),
    .DEPTH     (DEPTH),
    .PTR_W     (PTR_W),
    .LEN_W     (LEN_W),
    .PORT_W    (PORT_W)
  ) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .sched_valid  (sched_valid),
    .sched_port   (sched_port),
    .sched_ptr    (sched_ptr),
    .sched_len    (sched_len),
    .credit_valid (credit_valid),
    .credit_port  (credit_port),
    .tx_valid     (tx_valid),
    .tx_port      (tx_port),
    .tx_ptr       (tx_ptr),
    .tx_len       (tx_len),
    .tx_ready     (tx_ready),
    .tx_pause     (tx_pause),
    .ovf_err      (ovf_err)
  );

  // Expected issue order and credit order (credits follow pop order).
  task automatic push(input int p, input int ptr, input int len);
    desc_t d;
    d.port = PORT_W'(p);
    d.ptr  = PTR_W'(ptr);
    d.len  = LEN_W'(len);
    exp_tx.push_back(d);
    exp_crd.push_back(PORT_W'(p));
  endtask

  // Present one descriptor for one cycle; called at posedge+1.
  task automatic send(input int p, input int ptr, input int len);
    sched_valid = 1'b1;
    sched_port  = PORT_W'(p);
    sched_ptr   = PTR_W'(ptr);
    sched_len   = LEN_W'(len);
    @(posedge clk); #1;
    sched_valid = 1'b0;
  endtask

  // Bounded wait for the scoreboard to empty, plus a few idle cycles so a
  // stray extra issue or credit would reach the monitor.
  task automatic wait_drain();
    int i;
    i = 0;
    while ((exp_tx.size() != 0 || exp_crd.size() != 0) && i < 80) begin
      @(negedge clk);
      i++;
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic monitor();
    desc_t got, e;
    logic [PORT_W-1:0] ep;
    forever begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        got.port = tx_port;
        got.ptr  = tx_ptr;
        got.len  = tx_len;
        n_checks++;
        if (exp_tx.size() == 0) begin
          n_fails++;
          $display("FAIL tx_unexpected: got port %0d ptr %h len %0d, none expected", tx_port, tx_ptr, tx_len);
        end else begin
          e = exp_tx.pop_front();
          if (got !== e)
            begin n_fails++;
            $display("FAIL tx_order: got port %0d ptr %h len %0d, expected port %0d ptr %h len %0d",
                     got.port, got.ptr, got.len, e.port, e.ptr, e.len); end
        end
      end
      if (credit_valid) begin
        credit_seen++;
        n_checks++;
        if (exp_crd.size() == 0) begin
          n_fails++;
          $display("FAIL credit_unexpected: got credit port %0d, none expected", credit_port);
        end else begin
          ep = exp_crd.pop_front();
          if (credit_port !== ep) begin
            n_fails++;
            $display("FAIL credit_order: got port %0d, expected %0d", credit_port, ep);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({tx_valid, tx_port, tx_ptr, tx_len, credit_valid, credit_port, ovf_err} !== '0) begin
      n_fails++;
      $display("FAIL reset_in: valid=%b port=%0d ptr=%h len=%0d cv=%b cp=%0d ovf=%b, expected all 0",
               tx_valid, tx_port, tx_ptr, tx_len, credit_valid, credit_port, ovf_err);
    end
    repeat (3) @(posedge clk);
    #1 arst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b0 || credit_valid !== 1'b0 || ovf_err !== 4'b0000) begin
      n_fails++;
      $display("FAIL reset_out: valid=%b cv=%b ovf=%b, expected 0 0 0000", tx_valid, credit_valid, ovf_err);
    end
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    tx_ready = 1'b1;
    push(2, 'h00123, 64);
    sched_valid = 1'b1; sched_port = 2'd2; sched_ptr = 20'h00123; sched_len = 14'd64;
    @(negedge clk);                        // cycle 0
    n_checks++;
    if (tx_valid !== 1'b0) begin n_fails++; $display("FAIL single_c0: tx_valid=%b, expected 0", tx_valid); end
    @(posedge clk); #1;
    sched_valid = 1'b0;
    @(negedge clk);                        // cycle 1
    n_checks++;
    if (tx_valid !== 1'b0) begin n_fails++; $display("FAIL single_c1: tx_valid=%b, expected 0", tx_valid); end
    @(negedge clk);                        // cycle 2
    n_checks++;
    if (tx_valid !== 1'b1 || tx_port !== 2'd2 || tx_ptr !== 20'h00123 || tx_len !== 14'd64) begin
      n_fails++;
      $display("FAIL single_c2: valid=%b port=%0d ptr=%h len=%0d, expected 1 2 00123 64", tx_valid, tx_port, tx_ptr, tx_len);
    end
    n_checks++;
    if (credit_valid !== 1'b0) begin n_fails++; $display("FAIL single_crd_c2: credit_valid=%b, expected 0", credit_valid); end
    @(negedge clk);                        // cycle 3
    n_checks++;
    if (credit_valid !== 1'b1 || credit_port !== 2'd2) begin
      n_fails++;
      $display("FAIL single_crd_c3: cv=%b cp=%0d, expected 1 2", credit_valid, credit_port);
    end
    n_checks++;
    if (ovf_err !== 4'b0000) begin n_fails++; $display("FAIL single_ovf: ovf=%b, expected 0000", ovf_err); end
    wait_drain();
    n_checks++;
    if (exp_tx.size() != 0 || exp_crd.size() != 0) begin
      n_fails++; $display("FAIL single_drain: %0d tx / %0d credits outstanding, expected 0", exp_tx.size(), exp_crd.size());
    end
  endtask

  task automatic test_round_robin();
    int ports[6] = '{0, 1, 3, 0, 1, 3};
    @(posedge clk); #1;
    tx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push(ports[i], 'h100 + i, 200 + i);
      send(ports[i], 'h100 + i, 200 + i);
    end
    wait_drain();
    n_checks++;
    if (exp_tx.size() != 0 || exp_crd.size() != 0) begin
      n_fails++; $display("FAIL rr_drain: %0d tx / %0d credits outstanding, expected 0", exp_tx.size(), exp_crd.size());
    end
  endtask

  // All four ports waiting behind a held output; rr_ptr sits at 1 after the
  // port-0 load, so the rotation must go 1,2,3,0.
  task automatic test_rr_contend();
    int ports[4] = '{3, 1, 0, 2};
    int ptrs[4]  = '{'h203, 'h201, 'h210, 'h202};
    @(posedge clk); #1;
    tx_ready = 1'b0;
    push(0, 'h200, 10);
    send(0, 'h200, 10);
    for (int i = 0; i < 4; i++) send(ports[i], ptrs[i], 10);
    @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b1 || tx_ptr !== 20'h00200) begin
      n_fails++; $display("FAIL contend_hold: valid=%b ptr=%h, expected 1 00200", tx_valid, tx_ptr);
    end
    push(1, 'h201, 10); push(2, 'h202, 10); push(3, 'h203, 10); push(0, 'h210, 10);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_drain();
    n_checks++;
    if (exp_tx.size() != 0 || exp_crd.size() != 0) begin
      n_fails++; $display("FAIL contend_drain: %0d tx / %0d credits outstanding, expected 0", exp_tx.size(), exp_crd.size());
    end
  endtask

  task automatic test_back_pressure();
    int base;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    base = credit_seen;
    for (int i = 0; i < 3; i++) begin
      push(1, 'h300 + i, 100 + i);
      send(1, 'h300 + i, 100 + i);
    end
    for (int c = 3; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (tx_valid !== 1'b1 || tx_port !== 2'd1 || tx_ptr !== 20'h00300 || tx_len !== 14'd100) begin
        n_fails++;
        $display("FAIL bp_hold_c%0d: valid=%b port=%0d ptr=%h len=%0d, expected 1 1 00300 100", c, tx_valid, tx_port, tx_ptr, tx_len);
      end
    end
    n_checks++;
    if (credit_seen - base != 1) begin
      n_fails++; $display("FAIL bp_credits: %0d credits while stalled, expected 1", credit_seen - base);
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (tx_valid !== 1'b1 || tx_ptr !== PTR_W'('h300 + i)) begin
        n_fails++; $display("FAIL bp_burst_%0d: valid=%b ptr=%h, expected 1 %h", i, tx_valid, tx_ptr, 'h300 + i);
      end
    end
    wait_drain();
    n_checks++;
    if (exp_tx.size() != 0 || exp_crd.size() != 0) begin
      n_fails++; $display("FAIL bp_drain: %0d tx / %0d credits outstanding, expected 0", exp_tx.size(), exp_crd.size());
    end
  endtask

  task automatic test_pause();
    @(posedge clk); #1;
    tx_ready = 1'b1;
    tx_pause = 4'b0001;
    push(1, 'h401, 30); push(1, 'h402, 31);
    send(0, 'h400, 29);
    send(1, 'h401, 30);
    send(1, 'h402, 31);
    repeat (6) @(negedge clk);
    #1;
    n_checks++;
    if (exp_tx.size() != 0 || tx_valid !== 1'b0) begin
      n_fails++; $display("FAIL pause_block: %0d port1 outstanding, tx_valid=%b, expected 0 0", exp_tx.size(), tx_valid);
    end
    @(posedge clk); #1;                    // cycle M: release
    push(0, 'h400, 29);
    tx_pause = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b0) begin n_fails++; $display("FAIL pause_rel_m: tx_valid=%b, expected 0", tx_valid); end
    @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b1 || tx_port !== 2'd0 || tx_ptr !== 20'h00400) begin
      n_fails++; $display("FAIL pause_rel_m1: valid=%b port=%0d ptr=%h, expected 1 0 00400", tx_valid, tx_port, tx_ptr);
    end
    wait_drain();
    // Pause arriving after the load must not revoke the held descriptor.
    @(posedge clk); #1;
    tx_ready = 1'b0;
    push(0, 'h410, 40);
    send(0, 'h410, 40);
    repeat (2) @(posedge clk);
    #1 tx_pause = 4'b0001;
    tx_ready = 1'b1;
    wait_drain();
    tx_pause = 4'b0000;
    n_checks++;
    if (exp_tx.size() != 0 || exp_crd.size() != 0) begin
      n_fails++; $display("FAIL pause_drain: %0d tx / %0d credits outstanding, expected 0", exp_tx.size(), exp_crd.size());
    end
  endtask

  task automatic test_overflow();
    @(posedge clk); #1;
    tx_ready = 1'b0;
    push(0, 'h500, 50);
    send(0, 'h500, 50);
    for (int i = 0; i < 4; i++) send(3, 'h510 + i, 60 + i);
    @(negedge clk);
    n_checks++;
    if (ovf_err !== 4'b0000) begin n_fails++; $display("FAIL ovf_at_full: ovf=%b, expected 0000", ovf_err); end
    send(3, 'h514, 64);
    @(negedge clk);
    n_checks++;
    if (ovf_err !== 4'b1000) begin n_fails++; $display("FAIL ovf_set: ovf=%b, expected 1000", ovf_err); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (ovf_err !== 4'b1000) begin n_fails++; $display("FAIL ovf_sticky: ovf=%b, expected 1000", ovf_err); end
    for (int i = 0; i < 4; i++) push(3, 'h510 + i, 60 + i);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_drain();
    n_checks++;
    if (exp_tx.size() != 0 || exp_crd.size() != 0 || ovf_err !== 4'b1000) begin
      n_fails++; $display("FAIL ovf_drain: %0d tx / %0d credits outstanding ovf=%b, expected 0 0 1000",
                          exp_tx.size(), exp_crd.size(), ovf_err);
    end
  endtask

  task automatic test_full_pop();
    @(posedge clk); #1;
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(2, 'h600 + i, 70 + i);
    for (int i = 0; i < 5; i++) send(2, 'h600 + i, 70 + i);
    // port 2 holds four entries, output holds the first; pop and write together
    tx_ready = 1'b1;
    send(2, 'h605, 75);
    @(negedge clk);
    n_checks++;
    if (ovf_err[2] !== 1'b0) begin n_fails++; $display("FAIL fullpop_ovf: ovf=%b, expected bit2 0", ovf_err); end
    wait_drain();
    n_checks++;
    if (exp_tx.size() != 0 || exp_crd.size() != 0 || ovf_err !== 4'b1000) begin
      n_fails++; $display("FAIL fullpop_drain: %0d tx / %0d credits outstanding ovf=%b, expected 0 0 1000",
                          exp_tx.size(), exp_crd.size(), ovf_err);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    exp_crd.push_back(2'd1);               // first entry popped before reset
    for (int i = 0; i < 3; i++) send(1, 'h700 + i, 80);
    @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b1) begin n_fails++; $display("FAIL rstmid_pre: tx_valid=%b, expected 1", tx_valid); end
    @(posedge clk); #1;
    arst_n = 1'b0;
    #1;
    n_checks++;
    if (tx_valid !== 1'b0 || credit_valid !== 1'b0 || ovf_err !== 4'b0000 || tx_ptr !== 20'h0) begin
      n_fails++; $display("FAIL rstmid_async: valid=%b cv=%b ovf=%b ptr=%h, expected 0 0 0000 0",
                          tx_valid, credit_valid, ovf_err, tx_ptr);
    end
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
    tx_ready = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (tx_valid !== 1'b0 || credit_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fails++; $display("FAIL rstmid_flushed: %0d cycles with output after reset, expected 0", bad); end
    n_checks++;
    if (exp_crd.size() != 0) begin n_fails++; $display("FAIL rstmid_credit: %0d credits missing, expected 0", exp_crd.size()); end
  endtask

  initial begin
    sched_valid = 1'b0;
    sched_port  = '0;
    sched_ptr   = '0;
    sched_len   = '0;
    tx_ready    = 1'b0;
    tx_pause    = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_round_robin();
    test_rr_contend();
    test_back_pressure();
    test_pause();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
